// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter slice.
package mips_regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

    // Register 0 is hard-wired: never written, never tracked as busy.
    localparam reg_addr_t REG_ZERO = '0;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_PIPE = 2'd1,
        GRANT_AUX  = 2'd2
    } grant_e;

endpackage : mips_regfile_pkg

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the WB stage / long-latency unit / issue stage and the
// write arbiter. The slave modport is the arbiter's view.
interface regfile_write_arbiter_if;
    import mips_regfile_pkg::*;

    // Pipeline WB write request
    logic             PipeWrEn_IN;
    reg_addr_t        PipeWrReg_IN;
    reg_data_t        PipeWrData_IN;

    // Long-latency result handshake
    logic             AuxValid_IN;
    reg_addr_t        AuxWrReg_IN;
    reg_data_t        AuxWrData_IN;
    logic             AuxReady_OUT;

    // Issue-stage scoreboard interface
    logic             IssueValid_IN;
    reg_addr_t        IssueDestReg_IN;
    reg_addr_t        ChkSrc1_IN;
    reg_addr_t        ChkSrc2_IN;
    reg_addr_t        ChkDest_IN;
    logic             Hazard_OUT;
    logic             PipeStall_OUT;
    logic [NUM_REGS-1:0] BusyVec_OUT;

    // Register-file write port
    logic             RegWriteEnable_OUT;
    reg_addr_t        RegWriteRegister_OUT;
    reg_data_t        RegWriteData_OUT;

    modport master (
        output PipeWrEn_IN, PipeWrReg_IN, PipeWrData_IN,
        output AuxValid_IN, AuxWrReg_IN, AuxWrData_IN,
        input  AuxReady_OUT,
        output IssueValid_IN, IssueDestReg_IN,
        output ChkSrc1_IN, ChkSrc2_IN, ChkDest_IN,
        input  Hazard_OUT, PipeStall_OUT, BusyVec_OUT,
        input  RegWriteEnable_OUT, RegWriteRegister_OUT, RegWriteData_OUT
    );

    modport slave (
        input  PipeWrEn_IN, PipeWrReg_IN, PipeWrData_IN,
        input  AuxValid_IN, AuxWrReg_IN, AuxWrData_IN,
        output AuxReady_OUT,
        input  IssueValid_IN, IssueDestReg_IN,
        input  ChkSrc1_IN, ChkSrc2_IN, ChkDest_IN,
        output Hazard_OUT, PipeStall_OUT, BusyVec_OUT,
        output RegWriteEnable_OUT, RegWriteRegister_OUT, RegWriteData_OUT
    );

endinterface : regfile_write_arbiter_if

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register marking an
// outstanding long-latency write, with three combinational lookup ports.
module regfile_scoreboard
    import mips_regfile_pkg::*;
(
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                set_en_i,
    input  reg_addr_t           set_reg_i,
    input  logic                clr_en_i,
    input  reg_addr_t           clr_reg_i,
    input  reg_addr_t           lookup_a_i,
    input  reg_addr_t           lookup_b_i,
    input  reg_addr_t           lookup_c_i,
    output logic                busy_a_o,
    output logic                busy_b_o,
    output logic                busy_c_o,
    output logic [NUM_REGS-1:0] busy_vec_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: clear first, then set, so a same-cycle issue wins.
    always_comb begin
        // NOTE: start from the held value so every path assigns busy_d and no latch is inferred.
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_reg_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_reg_i] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // Busy vector register, dropped entirely on reset.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            // NOTE: this is 32 flops, not a RAM, so an async reset of every bit is cheap and intended.
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking so all flops sample pre-edge values regardless of block order.
            busy_q <= busy_d;
        end
    end

    assign busy_a_o   = busy_q[lookup_a_i];
    assign busy_b_o   = busy_q[lookup_b_i];
    assign busy_c_o   = busy_q[lookup_c_i];
    assign busy_vec_o = busy_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: grants the single write port to the WB
// stage or the long-latency unit, forces a one-cycle stall when the
// long-latency unit starves, and tracks outstanding writes for hazards.
module regfile_write_arbiter
    import mips_regfile_pkg::*;
#(
    parameter int REG_ADDR_W   = mips_regfile_pkg::REG_ADDR_W,
    parameter int DATA_W       = mips_regfile_pkg::DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    regfile_write_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(STARVE_LIMIT - 1);
    localparam cnt_t CNT_MAX  = cnt_t'(STARVE_LIMIT);

    logic                  pipe_req;
    logic                  aux_xfer;
    logic                  aux_blocked;
    grant_e                grant;

    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0]     wr_data;

    cnt_t                  cnt_q;
    cnt_t                  cnt_d;
    logic                  stall_q;
    logic                  stall_d;

    logic                  busy_src1;
    logic                  busy_src2;
    logic                  busy_dest;

    // A WB write to r0 is a no-op and must not steal the port.
    assign pipe_req = bus.PipeWrEn_IN && (bus.PipeWrReg_IN != REG_ZERO);

    // Priority grant: forced stall favours aux, else pipe, else aux.
    always_comb begin
        grant = GRANT_NONE;
        if (stall_q && bus.AuxValid_IN) begin
            grant = GRANT_AUX;
        end else if (pipe_req) begin
            grant = GRANT_PIPE;
        end else if (bus.AuxValid_IN) begin
            grant = GRANT_AUX;
        end
    end

    assign bus.AuxReady_OUT = (grant == GRANT_AUX);
    assign aux_xfer         = bus.AuxValid_IN && bus.AuxReady_OUT;
    assign aux_blocked      = bus.AuxValid_IN && !bus.AuxReady_OUT;

    // Write-port mux from the granted source; aux writes to r0 only handshake.
    always_comb begin
        wr_en   = 1'b0;
        wr_reg  = bus.PipeWrReg_IN;
        wr_data = bus.PipeWrData_IN;
        case (grant)
            GRANT_PIPE: wr_en = 1'b1;
            GRANT_AUX: begin
                wr_en   = (bus.AuxWrReg_IN != REG_ZERO);
                wr_reg  = bus.AuxWrReg_IN;
                wr_data = bus.AuxWrData_IN;
            end
            default: wr_en = 1'b0;
        endcase
    end

    assign bus.RegWriteEnable_OUT   = wr_en;
    assign bus.RegWriteRegister_OUT = wr_reg;
    assign bus.RegWriteData_OUT     = wr_data;

    // Starvation tracking: count blocked cycles, raise stall on the last one.
    always_comb begin
        cnt_d   = '0;
        stall_d = stall_q;
        if (aux_blocked) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + cnt_t'(1);
        end
        if (aux_xfer) begin
            stall_d = 1'b0;
        end else if (aux_blocked && (cnt_q == CNT_LAST)) begin
            stall_d = 1'b1;
        end
    end

    // Starve counter and stall flag registers.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign bus.PipeStall_OUT = stall_q;

    regfile_scoreboard u_scoreboard (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .set_en_i   (bus.IssueValid_IN),
        .set_reg_i  (bus.IssueDestReg_IN),
        .clr_en_i   (aux_xfer),
        .clr_reg_i  (bus.AuxWrReg_IN),
        .lookup_a_i (bus.ChkSrc1_IN),
        .lookup_b_i (bus.ChkSrc2_IN),
        .lookup_c_i (bus.ChkDest_IN),
        .busy_a_o   (busy_src1),
        .busy_b_o   (busy_src2),
        .busy_c_o   (busy_dest),
        .busy_vec_o (bus.BusyVec_OUT)
    );

    assign bus.Hazard_OUT = busy_src1 || busy_src2 || busy_dest;

endmodule : regfile_write_arbiter

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (STARVE_LIMIT=4).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_regfile_write_arbiter;
    import mips_regfile_pkg::*;

    logic CLOCK;
    logic RESET;
    int   errors = 0;
    int   checks = 0;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(
        .REG_ADDR_W   (5),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic set_idle();
        bus.PipeWrEn_IN     = 1'b0;
        bus.PipeWrReg_IN    = '0;
        bus.PipeWrData_IN   = '0;
        bus.AuxValid_IN     = 1'b0;
        bus.AuxWrReg_IN     = '0;
        bus.AuxWrData_IN    = '0;
        bus.IssueValid_IN   = 1'b0;
        bus.IssueDestReg_IN = '0;
        bus.ChkSrc1_IN      = '0;
        bus.ChkSrc2_IN      = '0;
        bus.ChkDest_IN      = '0;
    endtask

    // Start a new cycle: wait past the falling edge and return inputs to idle.
    task automatic step();
        @(negedge CLOCK);
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        RESET = 1'b0;
        #13;
        checks++; if (bus.BusyVec_OUT !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected %h", bus.BusyVec_OUT, 32'h0); end
        checks++; if (bus.PipeStall_OUT !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.PipeStall_OUT); end
        checks++; if (bus.AuxReady_OUT !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.AuxReady_OUT); end
        checks++; if (bus.RegWriteEnable_OUT !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.RegWriteEnable_OUT); end
        checks++; if (bus.Hazard_OUT !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", bus.Hazard_OUT); end
        @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    task automatic test_pipe_write();
        step();
        bus.PipeWrEn_IN = 1'b1; bus.PipeWrReg_IN = 5'd5; bus.PipeWrData_IN = 32'hDEADBEEF;
        #1;
        checks++; if (bus.RegWriteEnable_OUT !== 1'b1) begin errors++; $display("FAIL pipe_we: got %b expected 1", bus.RegWriteEnable_OUT); end
        checks++; if (bus.RegWriteRegister_OUT !== 5'd5) begin errors++; $display("FAIL pipe_reg: got %0d expected 5", bus.RegWriteRegister_OUT); end
        checks++; if (bus.RegWriteData_OUT !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_data: got %h expected deadbeef", bus.RegWriteData_OUT); end
        checks++; if (bus.AuxReady_OUT !== 1'b0) begin errors++; $display("FAIL pipe_ready: got %b expected 0", bus.AuxReady_OUT); end
        // A WB write to r0 is not a request at all
        step();
        bus.PipeWrEn_IN = 1'b1; bus.PipeWrReg_IN = 5'd0; bus.PipeWrData_IN = 32'h1111;
        #1;
        checks++; if (bus.RegWriteEnable_OUT !== 1'b0) begin errors++; $display("FAIL pipe_r0_we: got %b expected 0", bus.RegWriteEnable_OUT); end
    endtask

    task automatic test_idle_aux();
        step();
        bus.IssueValid_IN = 1'b1; bus.IssueDestReg_IN = 5'd7;
        step();
        bus.AuxValid_IN = 1'b1; bus.AuxWrReg_IN = 5'd7; bus.AuxWrData_IN = 32'h12; bus.ChkSrc1_IN = 5'd7;
        #1;
        checks++; if (bus.BusyVec_OUT !== 32'h80) begin errors++; $display("FAIL aux_busy_set: got %h expected 00000080", bus.BusyVec_OUT); end
        checks++; if (bus.AuxReady_OUT !== 1'b1) begin errors++; $display("FAIL aux_ready: got %b expected 1", bus.AuxReady_OUT); end
        checks++; if (bus.RegWriteEnable_OUT !== 1'b1) begin errors++; $display("FAIL aux_we: got %b expected 1", bus.RegWriteEnable_OUT); end
        checks++; if (bus.RegWriteRegister_OUT !== 5'd7) begin errors++; $display("FAIL aux_reg: got %0d expected 7", bus.RegWriteRegister_OUT); end
        checks++; if (bus.RegWriteData_OUT !== 32'h12) begin errors++; $display("FAIL aux_data: got %h expected 00000012", bus.RegWriteData_OUT); end
        checks++; if (bus.Hazard_OUT !== 1'b1) begin errors++; $display("FAIL aux_hazard_same: got %b expected 1", bus.Hazard_OUT); end
        step();
        bus.ChkSrc1_IN = 5'd7;
        #1;
        checks++; if (bus.BusyVec_OUT !== 32'h0) begin errors++; $display("FAIL aux_busy_clr: got %h expected 0", bus.BusyVec_OUT); end
        checks++; if (bus.Hazard_OUT !== 1'b0) begin errors++; $display("FAIL aux_hazard_next: got %b expected 0", bus.Hazard_OUT); end
    endtask

    task automatic test_scoreboard();
        step();
        bus.IssueValid_IN = 1'b1; bus.IssueDestReg_IN = 5'd9; bus.ChkSrc1_IN = 5'd9;
        #1;
        checks++; if (bus.Hazard_OUT !== 1'b0) begin errors++; $display("FAIL sb_c0_hazard: got %b expected 0", bus.Hazard_OUT); end
        step();
        bus.ChkSrc2_IN = 5'd9;
        #1;
        checks++; if (bus.Hazard_OUT !== 1'b1) begin errors++; $display("FAIL sb_src2_hazard: got %b expected 1", bus.Hazard_OUT); end
        step();
        bus.ChkDest_IN = 5'd9;
        bus.AuxValid_IN = 1'b1; bus.AuxWrReg_IN = 5'd9; bus.AuxWrData_IN = 32'h99;
        #1;
        checks++; if (bus.AuxReady_OUT !== 1'b1) begin errors++; $display("FAIL sb_xfer_ready: got %b expected 1", bus.AuxReady_OUT); end
        checks++; if (bus.Hazard_OUT !== 1'b1) begin errors++; $display("FAIL sb_dest_hazard: got %b expected 1", bus.Hazard_OUT); end
        step();
        bus.ChkSrc1_IN = 5'd9;
        #1;
        checks++; if (bus.Hazard_OUT !== 1'b0) begin errors++; $display("FAIL sb_after_hazard: got %b expected 0", bus.Hazard_OUT); end
        checks++; if (bus.BusyVec_OUT !== 32'h0) begin errors++; $display("FAIL sb_after_busy: got %h expected 0", bus.BusyVec_OUT); end
    endtask

    task automatic test_same_cycle();
        step();
        bus.IssueValid_IN = 1'b1; bus.IssueDestReg_IN = 5'd3;
        step();
        bus.IssueValid_IN = 1'b1; bus.IssueDestReg_IN = 5'd3;
        bus.AuxValid_IN = 1'b1; bus.AuxWrReg_IN = 5'd3; bus.AuxWrData_IN = 32'h33;
        #1;
        checks++; if (bus.AuxReady_OUT !== 1'b1) begin errors++; $display("FAIL same_ready: got %b expected 1", bus.AuxReady_OUT); end
        step();
        bus.AuxValid_IN = 1'b1; bus.AuxWrReg_IN = 5'd3; bus.AuxWrData_IN = 32'h34;
        #1;
        checks++; if (bus.BusyVec_OUT !== 32'h8) begin errors++; $display("FAIL same_set_wins: got %h expected 00000008", bus.BusyVec_OUT); end
        step();
        #1;
        checks++; if (bus.BusyVec_OUT !== 32'h0) begin errors++; $display("FAIL same_cleared: got %h expected 0", bus.BusyVec_OUT); end
    endtask

    task automatic test_reg_zero();
        step();
        bus.AuxValid_IN = 1'b1; bus.AuxWrReg_IN = 5'd0; bus.AuxWrData_IN = 32'hFF;
        bus.IssueValid_IN = 1'b1; bus.IssueDestReg_IN = 5'd0;
        #1;
        checks++; if (bus.AuxReady_OUT !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b expected 1", bus.AuxReady_OUT); end
        checks++; if (bus.RegWriteEnable_OUT !== 1'b0) begin errors++; $display("FAIL r0_we: got %b expected 0", bus.RegWriteEnable_OUT); end
        step();
        #1;
        checks++; if (bus.BusyVec_OUT !== 32'h0) begin errors++; $display("FAIL r0_busy: got %h expected 0", bus.BusyVec_OUT); end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 4; i++) begin
            step();
            bus.PipeWrEn_IN = 1'b1; bus.PipeWrReg_IN = 5'd2; bus.PipeWrData_IN = 32'(i);
            bus.AuxValid_IN = 1'b1; bus.AuxWrReg_IN = 5'd11; bus.AuxWrData_IN = 32'hA5A5;
            #1;
            checks++; if (bus.AuxReady_OUT !== 1'b0) begin errors++; $display("FAIL starve_ready c%0d: got %b expected 0", i, bus.AuxReady_OUT); end
            checks++; if (bus.PipeStall_OUT !== 1'b0) begin errors++; $display("FAIL starve_stall c%0d: got %b expected 0", i, bus.PipeStall_OUT); end
            checks++; if (bus.RegWriteRegister_OUT !== 5'd2) begin errors++; $display("FAIL starve_reg c%0d: got %0d expected 2", i, bus.RegWriteRegister_OUT); end
        end
        step();
        bus.PipeWrEn_IN = 1'b1; bus.PipeWrReg_IN = 5'd2; bus.PipeWrData_IN = 32'h4;
        bus.AuxValid_IN = 1'b1; bus.AuxWrReg_IN = 5'd11; bus.AuxWrData_IN = 32'hA5A5;
        #1;
        checks++; if (bus.PipeStall_OUT !== 1'b1) begin errors++; $display("FAIL starve_stall c4: got %b expected 1", bus.PipeStall_OUT); end
        checks++; if (bus.AuxReady_OUT !== 1'b1) begin errors++; $display("FAIL starve_ready c4: got %b expected 1", bus.AuxReady_OUT); end
        checks++; if (bus.RegWriteRegister_OUT !== 5'd11) begin errors++; $display("FAIL starve_reg c4: got %0d expected 11", bus.RegWriteRegister_OUT); end
        checks++; if (bus.RegWriteData_OUT !== 32'hA5A5) begin errors++; $display("FAIL starve_data c4: got %h expected 0000a5a5", bus.RegWriteData_OUT); end
        step();
        bus.PipeWrEn_IN = 1'b1; bus.PipeWrReg_IN = 5'd2; bus.PipeWrData_IN = 32'h4;
        #1;
        checks++; if (bus.PipeStall_OUT !== 1'b0) begin errors++; $display("FAIL starve_stall c5: got %b expected 0", bus.PipeStall_OUT); end
        checks++; if (bus.RegWriteRegister_OUT !== 5'd2) begin errors++; $display("FAIL starve_reg c5: got %0d expected 2", bus.RegWriteRegister_OUT); end
    endtask

    task automatic test_back_to_back();
        // Pipe wins the first cycle, aux takes the very next idle slot
        step();
        bus.PipeWrEn_IN = 1'b1; bus.PipeWrReg_IN = 5'd1; bus.PipeWrData_IN = 32'h100;
        bus.AuxValid_IN = 1'b1; bus.AuxWrReg_IN = 5'd2; bus.AuxWrData_IN = 32'h200;
        #1;
        checks++; if (bus.RegWriteRegister_OUT !== 5'd1) begin errors++; $display("FAIL b2b_c0_reg: got %0d expected 1", bus.RegWriteRegister_OUT); end
        step();
        bus.AuxValid_IN = 1'b1; bus.AuxWrReg_IN = 5'd2; bus.AuxWrData_IN = 32'h200;
        #1;
        checks++; if (bus.RegWriteData_OUT !== 32'h200) begin errors++; $display("FAIL b2b_c1_data: got %h expected 00000200", bus.RegWriteData_OUT); end
        step();
        bus.AuxValid_IN = 1'b1; bus.AuxWrReg_IN = 5'd13; bus.AuxWrData_IN = 32'h300;
        #1;
        checks++; if (bus.AuxReady_OUT !== 1'b1 || bus.RegWriteRegister_OUT !== 5'd13) begin errors++; $display("FAIL b2b_c2: got ready=%b reg=%0d expected ready=1 reg=13", bus.AuxReady_OUT, bus.RegWriteRegister_OUT); end
    endtask

    task automatic test_reset_mid();
        step();
        bus.IssueValid_IN = 1'b1; bus.IssueDestReg_IN = 5'd4;
        step();
        bus.IssueValid_IN = 1'b1; bus.IssueDestReg_IN = 5'd6;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.PipeWrEn_IN = 1'b1; bus.PipeWrReg_IN = 5'd8; bus.PipeWrData_IN = 32'h8;
            bus.AuxValid_IN = 1'b1; bus.AuxWrReg_IN = 5'd12; bus.AuxWrData_IN = 32'hC;
        end
        #1;
        checks++; if (bus.PipeStall_OUT !== 1'b1) begin errors++; $display("FAIL rstmid_pre_stall: got %b expected 1", bus.PipeStall_OUT); end
        checks++; if (bus.BusyVec_OUT !== 32'h50) begin errors++; $display("FAIL rstmid_pre_busy: got %h expected 00000050", bus.BusyVec_OUT); end
        RESET = 1'b0;
        set_idle();
        #1;
        checks++; if (bus.BusyVec_OUT !== 32'h0) begin errors++; $display("FAIL rstmid_busy: got %h expected 0", bus.BusyVec_OUT); end
        checks++; if (bus.PipeStall_OUT !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", bus.PipeStall_OUT); end
        @(negedge CLOCK);
        RESET = 1'b1;
        step();
        #1;
        checks++; if (bus.PipeStall_OUT !== 1'b0 || bus.BusyVec_OUT !== 32'h0) begin errors++; $display("FAIL rstmid_after: got stall=%b busy=%h expected 0/0", bus.PipeStall_OUT, bus.BusyVec_OUT); end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_idle_aux();
        test_scoreboard();
        test_same_cycle();
        test_reg_zero();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_write_arbiter
